// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response channel between a client (master) and sram_ctrl (slave).
//   req_valid/req_ready : request handshake, accepted when both are high at a rising edge
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata  : word address and write data of the request
//   rsp_valid           : one-cycle completion pulse (no backpressure)
//   rsp_rdata/rsp_err   : read data and error flag, qualified by rsp_valid
interface sram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller. Each request runs
// SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> HOLD (1 cycle) -> RESP (1 cycle).
// All outputs are registered.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response channel, see sram_ctrl_if
//   cs, oe, we      : SRAM chip select, output enable, write enable
//   addr, din       : SRAM address and write data, stable while cs is high
//   dout            : SRAM read data, sampled at the end of the last ACCESS cycle
// Optional feature: define SRAM_CTRL_ALIGN_CHECK_EN to reject requests whose
// req_addr[1:0] != 0 with an immediate error response and no SRAM access.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1  // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_ctrl_if.slave        bus,
  output logic              cs,
  output logic              oe,
  output logic              we,
  output logic [31:0]       addr,
  output logic [31:0]       din,
  input  logic [31:0]       dout
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_we_q, op_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ready_q, ready_d;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    err_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && ready_q) begin
          op_we_d = bus.req_we;
          din_d   = bus.req_wdata;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error, never touch the SRAM.
            state_d = StResp;
            err_d   = 1'b1;
          end else begin
            addr_d  = bus.req_addr;
            state_d = StSetup;
          end
`else
          addr_d  = bus.req_addr;
          state_d = StSetup;
`endif
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = WaitInit;
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StHold;
          if (!op_we_q) rdata_d = dout;
        end
      end
      StHold:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are derived from the next state so the registered copies line up with it.
    cs_d        = (state_d == StSetup) || (state_d == StAccess) || (state_d == StHold);
    oe_d        = (state_d == StAccess) && !op_we_d;
    we_d        = (state_d == StAccess) && op_we_d;
    rsp_valid_d = (state_d == StResp);
    ready_d     = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      op_we_q     <= 1'b0;
      addr_q      <= 32'd0;
      din_q       <= 32'd0;
      rdata_q     <= 32'd0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign cs            = cs_q;
  assign oe            = oe_q;
  assign we            = we_q;
  assign addr          = addr_q;
  assign din           = din_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl. Two instances (WAIT_CYCLES = 1 and 4)
// share clock and reset, each attached to a small SRAM model. Directed table vectors,
// hand-written corner sequences and randomized transactions are compared against
// expectations computed here; SRAM pin invariants are checked every cycle.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if if1 ();
  sram_ctrl_if if4 ();

  logic        cs1, oe1, we1, cs4, oe4, we4;
  logic [31:0] addr1, din1, dout1, addr4, din4, dout4;

  sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .cs(cs1), .oe(oe1), .we(we1), .addr(addr1), .din(din1), .dout(dout1)
  );

  sram_ctrl #(.WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4),
    .cs(cs4), .oe(oe4), .we(we4), .addr(addr4), .din(din4), .dout(dout4)
  );

  // SRAM models: 256 words indexed by addr[9:2]; garbage on dout when oe is low.
  logic [31:0] mem1 [256];
  logic [31:0] mem4 [256];
  bit          init1 = 1'b0;
  bit          init4 = 1'b0;

  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'd0;
      init1 <= 1'b1;
    end else if (cs1 && we1) begin
      mem1[addr1[9:2]] <= din1;
    end
  end

  always @(posedge clk) begin
    if (!init4) begin
      for (int i = 0; i < 256; i++) mem4[i] <= 32'd0;
      mem4[8] <= 32'h8C09_0004;
      init4 <= 1'b1;
    end else if (cs4 && we4) begin
      mem4[addr4[9:2]] <= din4;
    end
  end

  assign dout1 = oe1 ? mem1[addr1[9:2]] : 32'hA5A5_A5A5;
  assign dout4 = oe4 ? mem4[addr4[9:2]] : 32'hA5A5_A5A5;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        cs, oe, we, rdy, rv, err;
    logic [31:0] addr, din, rdata;
  } obs_t;

  typedef struct {
    int          rsp_cyc, n_cs, n_oe, n_we, n_rsp, n_rdy_low, n_addr_bad;
    logic [31:0] rdata, addr1;
    logic        err, rdy_end;
  } res_t;

  typedef struct {
    bit          w;
    logic [31:0] a, d, exp_rdata;
  } vec_t;

  // Reference model: word store per instance plus last read value.
  logic [31:0] ref1 [logic [31:0]];
  logic [31:0] ref4 [logic [31:0]];
  logic [31:0] last1 = 32'd0;
  logic [31:0] last4 = 32'd0;

  logic        pcs1 = 1'b0, pcs4 = 1'b0;
  logic [31:0] pa1, pd1, pa4, pd4;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t snap(input int s);
    obs_t o;
    if (s == 4) begin
      o.cs = cs4; o.oe = oe4; o.we = we4; o.addr = addr4; o.din = din4;
      o.rdy = if4.req_ready; o.rv = if4.rsp_valid; o.err = if4.rsp_err;
      o.rdata = if4.rsp_rdata;
    end else begin
      o.cs = cs1; o.oe = oe1; o.we = we1; o.addr = addr1; o.din = din1;
      o.rdy = if1.req_ready; o.rv = if1.rsp_valid; o.err = if1.rsp_err;
      o.rdata = if1.rsp_rdata;
    end
    return o;
  endfunction

  task automatic proto();
    logic ok1, ok4;
    ok1 = !(oe1 && we1) && !((oe1 || we1) && !cs1) &&
          !(cs1 && pcs1 && (addr1 !== pa1 || din1 !== pd1));
    ok4 = !(oe4 && we4) && !((oe4 || we4) && !cs4) &&
          !(cs4 && pcs4 && (addr4 !== pa4 || din4 !== pd4));
    check("proto_dut1", {31'd0, ok1}, 32'd1);
    check("proto_dut4", {31'd0, ok4}, 32'd1);
    pcs1 = cs1; pa1 = addr1; pd1 = din1;
    pcs4 = cs4; pa4 = addr4; pd4 = din4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    proto();
  endtask

  task automatic drive(input int s, input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    if (s == 4) begin
      if4.req_valid = v; if4.req_we = w; if4.req_addr = a; if4.req_wdata = d;
    end else begin
      if1.req_valid = v; if1.req_we = w; if1.req_addr = a; if1.req_wdata = d;
    end
  endtask

  // Issue one request and observe cycles 1..4+W after the accept cycle.
  task automatic do_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit busy, output res_t r);
    obs_t o;
    int   k = 0;
    int   b = (s == 4) ? 8 : 5;
    r = '{rsp_cyc: -1, default: 0};
    o = snap(s);
    while (!o.rdy && k < 20) begin
      tick();
      o = snap(s);
      k++;
    end
    check($sformatf("ready_wait_dut%0d", s), {31'd0, o.rdy}, 32'd1);
    drive(s, 1'b1, w, a, d);
    tick();
    if (busy) drive(s, 1'b1, 1'b0, 32'h20, 32'h0);
    else      drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= b; c++) begin
      o = snap(s);
      if (o.cs) r.n_cs++;
      if (o.oe) r.n_oe++;
      if (o.we) r.n_we++;
      if (!o.rdy) r.n_rdy_low++;
      if (o.cs && o.addr !== a) r.n_addr_bad++;
      if (c == 1) r.addr1 = o.addr;
      if (o.rv) begin
        r.n_rsp++;
        if (r.rsp_cyc < 0) begin
          r.rsp_cyc = c;
          r.rdata   = o.rdata;
          r.err     = o.err;
        end
      end
      if (c < b) tick();
    end
    r.rdy_end = o.rdy;
  endtask

  task automatic check_txn(input string nm, input res_t r, input int cyc, input int ncs,
                           input int noe, input int nwe, input logic [31:0] rdata,
                           input logic err);
    check({nm, "_rsp_cycle"}, r.rsp_cyc, cyc);
    check({nm, "_rsp_count"}, r.n_rsp, 1);
    check({nm, "_cs_cycles"}, r.n_cs, ncs);
    check({nm, "_oe_cycles"}, r.n_oe, noe);
    check({nm, "_we_cycles"}, r.n_we, nwe);
    check({nm, "_rdata"}, r.rdata, rdata);
    check({nm, "_err"}, {31'd0, r.err}, {31'd0, err});
    check({nm, "_ready_low"}, r.n_rdy_low, cyc);
    check({nm, "_ready_end"}, {31'd0, r.rdy_end}, 32'd1);
    check({nm, "_addr_stable"}, r.n_addr_bad, 0);
  endtask

  initial begin
    vec_t vecs [7];
    res_t r;
    obs_t o;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset values while rst_n is low.
    #12;
    for (int s = 1; s <= 4; s += 3) begin
      o = snap(s);
      check($sformatf("reset_ctrl_dut%0d", s), {26'd0, o.cs, o.oe, o.we, o.rdy, o.rv, o.err},
            32'd0);
      check($sformatf("reset_addr_dut%0d", s), o.addr, 32'd0);
      check($sformatf("reset_din_dut%0d", s), o.din, 32'd0);
      check($sformatf("reset_rdata_dut%0d", s), o.rdata, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("ready_after_reset_dut1", {31'd0, if1.req_ready}, 32'd1);
    check("ready_after_reset_dut4", {31'd0, if4.req_ready}, 32'd1);

    // Directed table on the WAIT_CYCLES=1 instance.
    vecs[0] = '{w: 1'b1, a: 32'h1000_0000, d: 32'hDEAD_BEEF, exp_rdata: 32'h0000_0000};
    vecs[1] = '{w: 1'b0, a: 32'h1000_0000, d: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{w: 1'b1, a: 32'h1000_000C, d: 32'h1234_5678, exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{w: 1'b0, a: 32'h1000_000C, d: 32'h0,         exp_rdata: 32'h1234_5678};
    vecs[4] = '{w: 1'b1, a: 32'h1000_0000, d: 32'h0F0F_0F0F, exp_rdata: 32'h1234_5678};
    vecs[5] = '{w: 1'b0, a: 32'h1000_0000, d: 32'h0,         exp_rdata: 32'h0F0F_0F0F};
    vecs[6] = '{w: 1'b0, a: 32'h1000_0008, d: 32'h0,         exp_rdata: 32'h0000_0000};
    foreach (vecs[i]) begin
      do_txn(1, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, r);
      check_txn($sformatf("vec%0d", i), r, 4, 3, vecs[i].w ? 0 : 1, vecs[i].w ? 1 : 0,
                vecs[i].exp_rdata, 1'b0);
      if (vecs[i].w) ref1[vecs[i].a] = vecs[i].d;
    end
    last1 = 32'h0;

    // Wait states on the WAIT_CYCLES=4 instance.
    ref4[32'h0040_0020] = 32'h8C09_0004;
    do_txn(4, 1'b0, 32'h0040_0020, 32'h0, 1'b0, r);
    check_txn("wait4_read", r, 7, 6, 4, 0, 32'h8C09_0004, 1'b0);
    last4 = 32'h8C09_0004;

    // Busy ignore: a second request held during the first is taken only after RESP.
    do_txn(1, 1'b1, 32'h10, 32'h55AA_55AA, 1'b1, r);
    check_txn("busy_first", r, 4, 3, 0, 1, last1, 1'b0);
    ref1[32'h10] = 32'h55AA_55AA;
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("busy_second_cs", {31'd0, cs1}, 32'd1);
    check("busy_second_addr", addr1, 32'h20);
    for (int i = 0; i < 4; i++) tick();
    last1 = 32'h0;

    // Misaligned address.
    do_txn(1, 1'b0, 32'h0000_0006, 32'h0, 1'b0, r);
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    check_txn("align_err", r, 1, 0, 0, 0, last1, 1'b1);
`else
    check_txn("align_pass", r, 4, 3, 1, 0, 32'h0, 1'b0);
    check("align_pass_addr", r.addr1, 32'h0000_0006);
    last1 = 32'h0;
`endif

    // Reset in the middle of a write access.
    drive(1, 1'b1, 1'b1, 32'h1000_0020, 32'h1111_2222);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("abort_we_before", {30'd0, cs1, we1}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_drop", {29'd0, cs1, we1, if1.rsp_valid}, 32'd0);
    tick();
    check("abort_ready_in_reset", {31'd0, if1.req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_ready_release", {31'd0, if1.req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_rsp", {31'd0, if1.rsp_valid}, 32'd0);
      tick();
    end
    last1 = 32'h0;
    last4 = 32'h0;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int          s;
      bit          w;
      logic [31:0] a, d, exp;
      s = ($urandom_range(0, 1) == 0) ? 1 : 4;
      w = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      d = $urandom;
      if (s == 4) begin
        if (w) exp = last4;
        else   exp = ref4.exists(a) ? ref4[a] : 32'h0;
        if (w) ref4[a] = d;
        else   last4 = exp;
      end else begin
        if (w) exp = last1;
        else   exp = ref1.exists(a) ? ref1[a] : 32'h0;
        if (w) ref1[a] = d;
        else   last1 = exp;
      end
      do_txn(s, w, a, d, 1'b0, r);
      check_txn($sformatf("rand%0d_dut%0d", i, s), r, (s == 4) ? 7 : 4, (s == 4) ? 6 : 3,
                w ? 0 : ((s == 4) ? 4 : 1), w ? ((s == 4) ? 4 : 1) : 0, exp, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set the number of cycles with oe/we asserted; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  input  1  SHALL signal that a request is present.
REQ-005 req_ready  output  1  SHALL signal that the controller accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select the request type: 1 = write, 0 = read.
REQ-007 req_addr  input  32  SHALL carry the word address.
REQ-008 req_wdata  input  32  SHALL carry the write data.
REQ-009 rsp_valid  output  1  SHALL be a one-cycle pulse marking request completion.
REQ-010 rsp_rdata  output  32  SHALL carry the read data, valid with rsp_valid on reads.
REQ-011 rsp_err  output  1  SHALL flag an error response, qualified by rsp_valid.
REQ-012 cs  output  1  SHALL drive the SRAM chip select.
REQ-013 oe  output  1  SHALL drive the SRAM output enable.
REQ-014 we  output  1  SHALL drive the SRAM write enable.
REQ-015 addr  output  32  SHALL drive the SRAM address.
REQ-016 din  output  32  SHALL drive the SRAM write data.
REQ-017 dout  input  32  SHALL receive the SRAM read data.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD and RESP; all outputs SHALL be registered.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clock edge where req_valid && req_ready, and its req_we/req_addr/req_wdata SHALL be latched.
REQ-020 IDLE -> SETUP on accept; in SETUP, cs=1, addr and din are driven, and oe=we=0 for 1 cycle.
REQ-021 SETUP -> ACCESS; in ACCESS, cs=1 and we=1 (write) or oe=1 (read) for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-022 On a read, dout SHALL be captured into rsp_rdata at the edge that ends the last ACCESS cycle.
REQ-023 ACCESS -> HOLD; in HOLD, cs=1, oe=we=0, and addr/din are unchanged for 1 cycle.
REQ-024 HOLD -> RESP; in RESP, cs=0, rsp_valid=1 for 1 cycle, then RESP -> IDLE.
REQ-025 Latency: rsp_valid SHALL be high in cycle 3+WAIT_CYCLES after the accept cycle; throughput is one request per 4+WAIT_CYCLES cycles.
REQ-026 oe and we SHALL never be 1 simultaneously; neither SHALL be 1 while cs=0.
REQ-027 addr and din SHALL be stable from SETUP through HOLD.
REQ-028 rsp_rdata SHALL hold its last read value across write responses and idle cycles.
REQ-029 req_valid in any non-IDLE state SHALL be ignored and SHALL NOT alter the in-flight transaction.
REQ-030 There SHALL be no response backpressure: rsp_valid is never held.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE and cs, oe, we, rsp_valid, rsp_err, req_ready SHALL be 0, with addr, din, rsp_rdata and the counter at 0.
REQ-032 rst_n asserted mid-transaction SHALL abort it immediately, with no response generated.
REQ-033 req_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-034 With SRAM_CTRL_ALIGN_CHECK_EN defined, an accepted request with req_addr[1:0] != 0 SHALL skip SETUP/ACCESS/HOLD, go directly to RESP with rsp_err=1, keep cs at 0, and leave rsp_rdata unchanged.
REQ-035 Without SRAM_CTRL_ALIGN_CHECK_EN, rsp_err SHALL be tied 0 and all addresses SHALL pass unmodified to addr.

Verification
REQ-036 Write then read: WAIT_CYCLES=1; write 0x10000000 <- 0xDEADBEEF, then read 0x10000000 -> cs high 3 cycles per access, we high 1 cycle, rsp_rdata=0xDEADBEEF in cycle 4 after accept.
REQ-037 Wait states: WAIT_CYCLES=4; read 0x00400020 with the model returning 0x8C090004 -> oe high exactly 4 cycles, rsp_valid in cycle 7, req_ready low cycles 1-7.
REQ-038 Busy ignore: req_valid held high with a new address 0x20 during ACCESS -> addr stays 0x10, and the second request is accepted only in the IDLE cycle after RESP.
REQ-039 Reset mid-access: rst_n=0 during ACCESS of a write -> cs/we drop to 0 asynchronously, no rsp_valid, and req_ready=1 in the first cycle after release.
REQ-040 Alignment (macro defined): read 0x00000006 -> cs never asserted, rsp_valid and rsp_err=1 in cycle 1; macro undefined -> normal access with addr=0x00000006 and rsp_err=0.
REQ-041 Protocol checker: in all scenarios, assert the REQ-026 and REQ-027 invariants every cycle.
